// File: rtl/rv32i_types.sv
// Shared RV32I decode types: opcodes, ALU/compare operations, datapath mux selects
// and the per-stage control word carried down the pipeline.
package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011
    } rv32i_opcode;

    // Encoded so that funct3 maps straight onto the op for add/sll/xor/or/and.
    typedef enum logic [2:0] {
        alu_add = 3'b000,
        alu_sll = 3'b001,
        alu_sra = 3'b010,
        alu_sub = 3'b011,
        alu_xor = 3'b100,
        alu_srl = 3'b101,
        alu_or  = 3'b110,
        alu_and = 3'b111
    } alu_ops;

    typedef enum logic [2:0] {
        beq  = 3'b000,
        bne  = 3'b001,
        blt  = 3'b100,
        bge  = 3'b101,
        bltu = 3'b110,
        bgeu = 3'b111
    } branch_funct3_t;

    localparam logic       AM1_RS1 = 1'b0;
    localparam logic       AM1_PC  = 1'b1;

    localparam logic [2:0] AM2_I_IMM = 3'd0;
    localparam logic [2:0] AM2_U_IMM = 3'd1;
    localparam logic [2:0] AM2_B_IMM = 3'd2;
    localparam logic [2:0] AM2_S_IMM = 3'd3;
    localparam logic [2:0] AM2_J_IMM = 3'd4;
    localparam logic [2:0] AM2_RS2   = 3'd5;

    localparam logic       CMP_RS2 = 1'b0;
    localparam logic       CMP_IMM = 1'b1;

    localparam logic [3:0] RFM_ALU   = 4'd0;
    localparam logic [3:0] RFM_BR_EN = 4'd1;
    localparam logic [3:0] RFM_U_IMM = 4'd2;
    localparam logic [3:0] RFM_LW    = 4'd3;
    localparam logic [3:0] RFM_PC4   = 4'd4;
    localparam logic [3:0] RFM_LB    = 4'd5;
    localparam logic [3:0] RFM_LBU   = 4'd6;
    localparam logic [3:0] RFM_LH    = 4'd7;
    localparam logic [3:0] RFM_LHU   = 4'd8;

    typedef struct packed {
        rv32i_opcode    opcode;
        alu_ops         aluop;
        branch_funct3_t cmpop;
        logic           alumux1_sel;
        logic [2:0]     alumux2_sel;
        logic           cmpmux_sel;
        logic [3:0]     regfilemux_sel;
        logic           load_regfile;
        logic           mem_read;
        logic           mem_write;
        logic [2:0]     mem_funct3;
        logic           is_branch;
        logic           is_jump;
    } rv32i_control_word;

    function automatic logic is_known_opcode(input logic [6:0] op);
        logic known;
        case (op)
            op_lui, op_auipc, op_jal, op_jalr, op_br,
            op_load, op_store, op_imm, op_reg: known = 1'b1;
            default:                           known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/ctrl_pipeline_decode.sv
// Combinational RV32I decoder: instruction fields to a control word plus an
// illegal-opcode flag. Unknown opcodes yield a word that is zero except for opcode.
module ctrl_decode
    import rv32i_types::*;
(
    input  logic [6:0]        opcode_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    output rv32i_control_word ctrl_o,
    output logic              illegal_o
);

    logic alt_s;

    // Field decode; every field starts at zero and only the matching opcode sets it.
    always_comb begin
        ctrl_o    = '0;
        illegal_o = !is_known_opcode(opcode_i);
        alt_s     = (funct7_i == 7'b0100000);
        case (opcode_i)
            op_lui: begin
                ctrl_o.load_regfile   = 1'b1;
                ctrl_o.regfilemux_sel = RFM_U_IMM;
            end
            op_auipc: begin
                ctrl_o.aluop        = alu_add;
                ctrl_o.alumux1_sel  = AM1_PC;
                ctrl_o.alumux2_sel  = AM2_U_IMM;
                ctrl_o.load_regfile = 1'b1;
            end
            op_jal: begin
                ctrl_o.aluop          = alu_add;
                ctrl_o.alumux1_sel    = AM1_PC;
                ctrl_o.alumux2_sel    = AM2_J_IMM;
                ctrl_o.load_regfile   = 1'b1;
                ctrl_o.regfilemux_sel = RFM_PC4;
                ctrl_o.is_jump        = 1'b1;
            end
            op_jalr: begin
                ctrl_o.aluop          = alu_add;
                ctrl_o.alumux1_sel    = AM1_RS1;
                ctrl_o.alumux2_sel    = AM2_I_IMM;
                ctrl_o.load_regfile   = 1'b1;
                ctrl_o.regfilemux_sel = RFM_PC4;
                ctrl_o.is_jump        = 1'b1;
            end
            op_br: begin
                ctrl_o.aluop       = alu_add;
                ctrl_o.alumux1_sel = AM1_PC;
                ctrl_o.alumux2_sel = AM2_B_IMM;
                ctrl_o.cmpop       = branch_funct3_t'(funct3_i);
                ctrl_o.is_branch   = 1'b1;
            end
            op_load: begin
                ctrl_o.aluop        = alu_add;
                ctrl_o.alumux2_sel  = AM2_I_IMM;
                ctrl_o.mem_read     = 1'b1;
                ctrl_o.load_regfile = 1'b1;
                ctrl_o.mem_funct3   = funct3_i;
                case (funct3_i)
                    3'b000:  ctrl_o.regfilemux_sel = RFM_LB;
                    3'b001:  ctrl_o.regfilemux_sel = RFM_LH;
                    3'b100:  ctrl_o.regfilemux_sel = RFM_LBU;
                    3'b101:  ctrl_o.regfilemux_sel = RFM_LHU;
                    default: ctrl_o.regfilemux_sel = RFM_LW;
                endcase
            end
            op_store: begin
                ctrl_o.aluop       = alu_add;
                ctrl_o.alumux2_sel = AM2_S_IMM;
                ctrl_o.mem_write   = 1'b1;
                ctrl_o.mem_funct3  = funct3_i;
            end
            op_imm: begin
                ctrl_o.alumux2_sel  = AM2_I_IMM;
                ctrl_o.load_regfile = 1'b1;
                case (funct3_i)
                    3'b010: begin
                        ctrl_o.cmpop          = blt;
                        ctrl_o.cmpmux_sel     = CMP_IMM;
                        ctrl_o.regfilemux_sel = RFM_BR_EN;
                    end
                    3'b011: begin
                        ctrl_o.cmpop          = bltu;
                        ctrl_o.cmpmux_sel     = CMP_IMM;
                        ctrl_o.regfilemux_sel = RFM_BR_EN;
                    end
                    3'b101:  ctrl_o.aluop = alt_s ? alu_sra : alu_srl;
                    default: ctrl_o.aluop = alu_ops'(funct3_i);
                endcase
            end
            op_reg: begin
                ctrl_o.alumux2_sel  = AM2_RS2;
                ctrl_o.load_regfile = 1'b1;
                case (funct3_i)
                    3'b000:  ctrl_o.aluop = alt_s ? alu_sub : alu_add;
                    3'b010: begin
                        ctrl_o.cmpop          = blt;
                        ctrl_o.cmpmux_sel     = CMP_RS2;
                        ctrl_o.regfilemux_sel = RFM_BR_EN;
                    end
                    3'b011: begin
                        ctrl_o.cmpop          = bltu;
                        ctrl_o.cmpmux_sel     = CMP_RS2;
                        ctrl_o.regfilemux_sel = RFM_BR_EN;
                    end
                    3'b101:  ctrl_o.aluop = alt_s ? alu_sra : alu_srl;
                    default: ctrl_o.aluop = alu_ops'(funct3_i);
                endcase
            end
            default: ctrl_o = '0;
        endcase
        ctrl_o.opcode = rv32i_opcode'(opcode_i);
    end

endmodule

// File: rtl/ctrl_pipeline.sv
// Multi-stage control-word pipeline with stall/flush, one-cycle illegal-opcode
// pulse and a saturating illegal-opcode counter.
module ctrl_pipeline
    import rv32i_types::*;
#(
    parameter int NUM_STAGES  = 3,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [6:0]                         opcode,
    input  logic [2:0]                         funct3,
    input  logic [6:0]                         funct7,
    input  logic                               stall,
    input  logic                               flush,
    output rv32i_control_word [NUM_STAGES-1:0] stage_ctrl,
    output logic [NUM_STAGES-1:0]              stage_valid,
    output logic                               illegal,
    output logic [CNT_W-1:0]                   illegal_count
);

    rv32i_control_word [NUM_STAGES-1:0] stage_ctrl_q, stage_ctrl_d;
    logic [NUM_STAGES-1:0]              stage_valid_q, stage_valid_d;
    logic                               illegal_q, illegal_d;
    logic [CNT_W-1:0]                   count_q, count_d;
    rv32i_control_word                  dec_ctrl_s;
    logic                               dec_illegal_s;
    logic                               accept_s;

    ctrl_decode u_decode (
        .opcode_i  (opcode),
        .funct3_i  (funct3),
        .funct7_i  (funct7),
        .ctrl_o    (dec_ctrl_s),
        .illegal_o (dec_illegal_s)
    );

    // Reset gating keeps the handshake closed while the pipeline is being cleared.
    assign in_ready = rst_n && !stall && !flush;
    assign accept_s = in_valid && in_ready;

    // Next-state for stages: shift/insert, hold on stall, then flush overrides the young end.
    always_comb begin
        stage_ctrl_d  = stage_ctrl_q;
        stage_valid_d = stage_valid_q;
        if (stall || flush) begin
            stage_ctrl_d[0]  = stage_ctrl_q[0];
            stage_valid_d[0] = stage_valid_q[0];
        end else begin
            stage_ctrl_d[0]  = accept_s ? dec_ctrl_s : '0;
            stage_valid_d[0] = accept_s;
        end
        for (int i = 1; i < NUM_STAGES; i++) begin
            if (!stall) begin
                stage_ctrl_d[i]  = stage_ctrl_q[i-1];
                stage_valid_d[i] = stage_valid_q[i-1];
            end else begin
                stage_ctrl_d[i]  = stage_ctrl_q[i];
                stage_valid_d[i] = stage_valid_q[i];
            end
        end
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (flush && (i < FLUSH_DEPTH)) begin
                stage_ctrl_d[i]  = '0;
                stage_valid_d[i] = 1'b0;
            end else begin
                stage_ctrl_d[i]  = stage_ctrl_d[i];
                stage_valid_d[i] = stage_valid_d[i];
            end
        end
    end

    // Illegal pulse and saturating counter next-state.
    always_comb begin
        illegal_d = accept_s && dec_illegal_s;
        if (illegal_d && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_ctrl_q  <= '0;
            stage_valid_q <= '0;
            illegal_q     <= 1'b0;
            count_q       <= '0;
        end else begin
            stage_ctrl_q  <= stage_ctrl_d;
            stage_valid_q <= stage_valid_d;
            illegal_q     <= illegal_d;
            count_q       <= count_d;
        end
    end

    assign stage_ctrl    = stage_ctrl_q;
    assign stage_valid   = stage_valid_q;
    assign illegal       = illegal_q;
    assign illegal_count = count_q;

endmodule

// File: doc/ctrl_pipeline.md
CTRL_PIPELINE -- requirements
Module: ctrl_pipeline

Interface
REQ-001 Parameter NUM_STAGES, default 3, number of pipelined control-word stages (legal 1..4).
REQ-002 Parameter FLUSH_DEPTH, default 2, number of youngest stages cleared by flush (legal 1..NUM_STAGES).
REQ-003 Parameter CNT_W, default 16, width of the illegal-opcode counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  decode request present this cycle.
REQ-007 in_ready  output  1  request accepted when in_valid && in_ready.
REQ-008 opcode  input  7  rv32i_opcode of the incoming instruction.
REQ-009 funct3  input  3  instruction funct3.
REQ-010 funct7  input  7  instruction funct7.
REQ-011 stall  input  1  hold all stages (memory not responding or hazard).
REQ-012 flush  input  1  squash the FLUSH_DEPTH youngest stages (branch redirect).
REQ-013 stage_ctrl  output  NUM_STAGES x rv32i_control_word  registered control word per stage; index 0 youngest.
REQ-014 stage_valid  output  NUM_STAGES  valid bit per stage.
REQ-015 illegal  output  1  one-cycle pulse, registered, when an unknown opcode is accepted.
REQ-016 illegal_count  output  CNT_W  saturating count of accepted unknown opcodes.

Function
REQ-017 in_ready SHALL equal !stall && !flush (combinational).
REQ-018 Decode SHALL be combinational from opcode/funct3/funct7; ctrl.opcode SHALL carry the input opcode; every other field SHALL default to 0 unless the opcode sets it.
REQ-019 Unknown opcode SHALL decode to an all-zero control word, still be accepted with stage_valid[0]=1 (NOP behaviour), and raise illegal the following cycle.
REQ-020 Latency: accepted request SHALL appear in stage_ctrl[0] one cycle later, in stage_ctrl[k] k+1 cycles later, absent stalls.
REQ-021 No stall, no flush: stage[i] <= stage[i-1] for i>=1; stage[0] <= decoded word with valid=1 on accept, else all-zero word with valid=0 (bubble).
REQ-022 stall && !flush: every stage SHALL hold ctrl and valid; no request accepted.
REQ-023 flush (any stall value): stages 0..FLUSH_DEPTH-1 SHALL load all-zero word, valid=0; stages >=FLUSH_DEPTH SHALL shift if !stall, hold if stall; no request accepted.
REQ-024 Oldest stage's contents SHALL be discarded on shift; no backpressure from the oldest stage.
REQ-025 illegal_count SHALL increment by 1 per accepted unknown opcode and saturate at 2^CNT_W-1 without wrap.
REQ-026 stage_ctrl SHALL be all-zero whenever the corresponding stage_valid is 0.

Reset
REQ-027 While rst_n=0 at a rising edge: all stage_valid=0, all stage_ctrl=0, illegal=0, illegal_count=0.
REQ-028 in_ready SHALL be 0 during the reset cycle; reset SHALL override stall and flush and abort any in-flight words.
REQ-029 First request SHALL be accepted on the first edge with rst_n=1.

Structure
REQ-030 rv32i_control_word, rv32i_opcode and alu/cmp op enums SHALL live in the shared rv32i_types package; the module SHALL add no private copies.
REQ-031 Decode SHALL be a separate combinational sub-module ctrl_decode (opcode, funct3, funct7 -> rv32i_control_word, illegal flag); ctrl_pipeline instantiates it once and owns all registers.

Verification
REQ-032 Reset then op_auipc accepted, no stall -> stage_ctrl[0].aluop=alu_add, valid=1 after 1 cycle; reaches stage 2 after 3 cycles.
REQ-033 Back-to-back op_lui, op_auipc, op_jal, stall high 2 cycles after second accept -> all stages frozen 2 cycles, in_ready=0, order preserved after release.
REQ-034 flush with stages 0..2 valid, FLUSH_DEPTH=2 -> stages 0,1 valid=0 and zero word next cycle; stage 2 receives old stage 1 contents.
REQ-035 opcode 7'h7F accepted -> stage_ctrl[0]=0 except opcode field, valid=1, illegal pulses 1 cycle, illegal_count=1; with CNT_W=2, 5 illegals -> count=3.
REQ-036 rst_n=0 asserted mid-stall with all stages valid -> next cycle all valid=0, illegal_count=0; stall+flush same cycle -> flush stages cleared, older stages held.
